// File: rtl/dlx_mem_arb.sv
// Memory arbiter for the DLX I-cache and D-cache: grants one side at a time and
// runs a LINE_WORDS-beat refill or write-back burst against a single memory port.
module dlx_mem_arb #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [31:0]                   dc_wdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic [31:0]                   rdata,
    output logic                          ic_rvalid,
    output logic                          dc_rvalid,
    output logic                          ic_done,
    output logic                          dc_done,
    output logic [$clog2(LINE_WORDS)-1:0] dc_beat,
    output logic                          busy
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    owner_e              pick;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                mem_req_q, busy_q, ic_done_q, dc_done_q;
    logic                beat_ack;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        base_d  = base_q;
        beat_d  = beat_q;
        // On a tie the side that did not own the previous burst wins.
        pick    = (dc_req && (!ic_req || last_q == OWN_I)) ? OWN_D : OWN_I;
        unique case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    owner_d = pick;
                    last_d  = pick;
                    we_d    = (pick == OWN_D) ? dc_we : 1'b0;
                    base_d  = ((pick == OWN_D) ? dc_addr : ic_addr) & ~OFF_MASK;
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (beat_q == LAST_BEAT) state_d = DONE;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_I;
            we_q      <= 1'b0;
            base_q    <= '0;
            beat_q    <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            mem_req_q <= (state_d == XFER);
            busy_q    <= (state_d != IDLE);
            ic_done_q <= (state_d == DONE) && (owner_d == OWN_I);
            dc_done_q <= (state_d == DONE) && (owner_d == OWN_D);
        end
    end

    // mem_req_q is high exactly while in XFER, so it gates every burst-phase output.
    assign beat_ack  = mem_req_q & mem_ack;
    assign mem_req   = mem_req_q;
    assign busy      = busy_q;
    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign mem_we    = mem_req_q & we_q;
    assign mem_addr  = mem_req_q ? (base_q + ADDR_W'({beat_q, 2'b00})) : '0;
    assign mem_wdata = (mem_req_q && owner_q == OWN_D && we_q) ? dc_wdata : '0;
    assign ic_rvalid = beat_ack && !we_q && (owner_q == OWN_I);
    assign dc_rvalid = beat_ack && !we_q && (owner_q == OWN_D);
    assign rdata     = (ic_rvalid || dc_rvalid) ? mem_rdata : '0;
    assign dc_beat   = mem_req_q ? beat_q : '0;

endmodule

// File: tb/tb_dlx_mem_arb.sv
// Directed bench for dlx_mem_arb: refill, tie arbitration, write-back, stalls,
// reset abort and top-of-memory alignment, each with hand-computed expectations.
module tb_dlx_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req, dc_we, mem_ack;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic        mem_req, mem_we, ic_rvalid, dc_rvalid, ic_done, dc_done, busy;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [1:0]  dc_beat;

    int errors = 0;
    int checks = 0;

    dlx_mem_arb #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rdata(rdata), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
        .ic_done(ic_done), .dc_done(dc_done), .dc_beat(dc_beat), .busy(busy)
    );

    always #5 clk = ~clk;

    // The D-cache supplies the write-back word for whichever beat is current.
    assign dc_wdata = 32'h0000_00A0 + 32'(dc_beat);

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((ic_rvalid && dc_rvalid) || (ic_done && dc_done)) begin
                errors++;
                $display("FAIL exclusive: rvalid=%b%b done=%b%b required no pair high",
                         ic_rvalid, dc_rvalid, ic_done, dc_done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
        ic_addr = 0; dc_addr = 0; mem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, rdata, ic_rvalid, dc_rvalid,
             ic_done, dc_done, dc_beat, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h busy=%b required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b mem_req=%b required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_ic_refill();
        ic_req = 1; ic_addr = 32'h0000_1234; mem_ack = 1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ic_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL refill_idle: mem_req=%b ic_rvalid=%b required 0 0", mem_req, ic_rvalid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hCAFE_0000 + 32'(i);
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_1230 + 32'(4 * i)) begin
                errors++;
                $display("FAIL refill_addr beat %0d: req=%b we=%b addr=%h required 1 0 %h",
                         i, mem_req, mem_we, mem_addr, 32'h0000_1230 + 32'(4 * i));
            end
            checks++;
            if (ic_rvalid !== 1'b1 || dc_rvalid !== 1'b0 || rdata !== 32'hCAFE_0000 + 32'(i)) begin
                errors++;
                $display("FAIL refill_data beat %0d: ic_rvalid=%b dc_rvalid=%b rdata=%h required 1 0 %h",
                         i, ic_rvalid, dc_rvalid, rdata, 32'hCAFE_0000 + 32'(i));
            end
            checks++;
            if (mem_wdata !== 32'h0 || ic_done !== 1'b0) begin
                errors++;
                $display("FAIL refill_side beat %0d: wdata=%h ic_done=%b required 0 0", i, mem_wdata, ic_done);
            end
            tick();
        end
        checks++;
        if (ic_done !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1 || ic_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL refill_done: ic_done=%b mem_req=%b busy=%b ic_rvalid=%b required 1 0 1 0",
                     ic_done, mem_req, busy, ic_rvalid);
        end
        ic_req = 0;
        tick();
        checks++;
        if (ic_done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || ic_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL refill_after: ic_done=%b busy=%b mem_req=%b ic_rvalid=%b required 0 0 0 0",
                     ic_done, busy, mem_req, ic_rvalid);
        end
        mem_ack = 0;
    endtask

    task automatic test_arbitration();
        logic [2:0]  exp_d;
        logic [31:0] exp_base;
        rst = 1; tick(); rst = 0;
        ic_req = 1; ic_addr = 32'h0000_0100;
        dc_req = 1; dc_we = 0; dc_addr = 32'h0000_0200;
        mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        exp_d = 3'b101;
        for (int n = 0; n < 3; n++) begin
            exp_base = exp_d[n] ? 32'h0000_0200 : 32'h0000_0100;
            tick();
            checks++;
            if (mem_addr !== exp_base || dc_rvalid !== exp_d[n] || ic_rvalid !== !exp_d[n]) begin
                errors++;
                $display("FAIL arb_grant %0d: addr=%h dc_rvalid=%b ic_rvalid=%b required %h %b %b",
                         n, mem_addr, dc_rvalid, ic_rvalid, exp_base, exp_d[n], !exp_d[n]);
            end
            tick(); tick(); tick();
            checks++;
            if (mem_addr !== exp_base + 32'hC) begin
                errors++;
                $display("FAIL arb_last_beat %0d: addr=%h required %h", n, mem_addr, exp_base + 32'hC);
            end
            tick();
            checks++;
            if (dc_done !== exp_d[n] || ic_done !== !exp_d[n]) begin
                errors++;
                $display("FAIL arb_done %0d: dc_done=%b ic_done=%b required %b %b",
                         n, dc_done, ic_done, exp_d[n], !exp_d[n]);
            end
            if (n == 2) begin
                ic_req = 0; dc_req = 0;
            end
            tick();
            checks++;
            if (busy !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL arb_idle_gap %0d: busy=%b mem_req=%b required 0 0", n, busy, mem_req);
            end
        end
        mem_ack = 0;
    endtask

    task automatic test_write_back();
        dc_req = 1; dc_we = 1; dc_addr = 32'h0000_0040; mem_ack = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0040 + 32'(4 * i) ||
                mem_wdata !== 32'h0000_00A0 + 32'(i)) begin
                errors++;
                $display("FAIL wb_beat %0d: we=%b addr=%h wdata=%h required 1 %h %h", i, mem_we,
                         mem_addr, mem_wdata, 32'h0000_0040 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
            end
            checks++;
            if (dc_rvalid !== 1'b0 || dc_beat !== 2'(i) || rdata !== 32'h0) begin
                errors++;
                $display("FAIL wb_side %0d: dc_rvalid=%b dc_beat=%0d rdata=%h required 0 %0d 0",
                         i, dc_rvalid, dc_beat, rdata, i);
            end
            tick();
        end
        checks++;
        if (dc_done !== 1'b1 || ic_done !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL wb_done: dc_done=%b ic_done=%b mem_we=%b required 1 0 0", dc_done, ic_done, mem_we);
        end
        dc_req = 0; dc_we = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_stall();
        logic [6:0]  ack_pat;
        logic [31:0] exp_addr;
        ack_pat  = 7'b1011001;
        exp_addr = 32'h0000_0800;
        ic_req = 1; ic_addr = 32'h0000_0800; mem_ack = 0;
        tick();
        for (int k = 0; k < 7; k++) begin
            mem_ack = ack_pat[k];
            #1;
            checks++;
            if (mem_addr !== exp_addr || ic_rvalid !== ack_pat[k] || ic_done !== 1'b0 || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle %0d: addr=%h rvalid=%b done=%b req=%b required %h %b 0 1",
                         k, mem_addr, ic_rvalid, ic_done, mem_req, exp_addr, ack_pat[k]);
            end
            tick();
            if (ack_pat[k]) exp_addr = exp_addr + 32'h4;
        end
        checks++;
        if (ic_done !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: ic_done=%b mem_req=%b required 1 0", ic_done, mem_req);
        end
        ic_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        ic_req = 1; ic_addr = 32'h0000_0300; mem_ack = 1;
        tick(); tick(); tick();
        checks++;
        if (mem_addr !== 32'h0000_0308) begin
            errors++;
            $display("FAIL abort_pre: addr=%h required 00000308", mem_addr);
        end
        dc_req = 1; dc_we = 0; dc_addr = 32'h0000_0500;
        ic_req = 0; rst = 1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || ic_rvalid !== 1'b0 || mem_addr !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: req=%b busy=%b rvalid=%b addr=%h rdata=%h required all 0",
                     mem_req, busy, ic_rvalid, mem_addr, rdata);
        end
        tick();
        checks++;
        if (ic_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: ic_done=%b required 0", ic_done);
        end
        rst = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || ic_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b ic_done=%b required 0 0", busy, ic_done);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0500 || dc_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL abort_regrant: req=%b addr=%h dc_rvalid=%b required 1 00000500 1",
                     mem_req, mem_addr, dc_rvalid);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (dc_done !== 1'b1 || ic_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_dc_done: dc_done=%b ic_done=%b required 1 0", dc_done, ic_done);
        end
        dc_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_wrap();
        ic_req = 1; ic_addr = 32'hFFFF_FFF8; mem_ack = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_addr !== 32'hFFFF_FFF0 + 32'(4 * i)) begin
                errors++;
                $display("FAIL wrap_addr beat %0d: addr=%h required %h", i, mem_addr, 32'hFFFF_FFF0 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (ic_done !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: ic_done=%b mem_req=%b required 1 0", ic_done, mem_req);
        end
        ic_req = 0; mem_ack = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ic_refill();
        test_arbitration();
        test_write_back();
        test_stall();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlx_mem_arb.md
DLX_MEM_ARB -- requirements
Module: dlx_mem_arb

Interface
REQ-001 Parameter LINE_WORDS, default 4, sets words per refill/write-back burst (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, sets byte-address width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ic_req  input  1  I-cache miss refill request; held high until ic_done.
REQ-006 ic_addr  input  ADDR_W  I-side miss byte address.
REQ-007 dc_req  input  1  D-cache request; held high until dc_done.
REQ-008 dc_we  input  1  D-side direction: 1 = write-back, 0 = refill.
REQ-009 dc_addr  input  ADDR_W  D-side byte address.
REQ-010 dc_wdata  input  32  D-side write-back word for the beat in dc_beat.
REQ-011 mem_req  output  1  memory beat request.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  ADDR_W  memory word byte address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_ack  input  1  beat accepted/complete this cycle.
REQ-016 mem_rdata  input  32  read data, valid with mem_ack.
REQ-017 rdata  output  32  read data forwarded to owner.
REQ-018 ic_rvalid / dc_rvalid  output  1 each  rdata valid for that side.
REQ-019 ic_done / dc_done  output  1 each  one-cycle burst-complete pulse.
REQ-020 dc_beat  output  log2(LINE_WORDS)  current beat index.
REQ-021 busy  output  1  high in every state other than IDLE.

Function
REQ-022 FSM states: IDLE, XFER, DONE.
REQ-023 IDLE: with no request, stay in IDLE and drive mem_req=0.
REQ-024 IDLE: with exactly one request, grant that side and enter XFER next cycle.
REQ-025 IDLE, both requesting: grant the side NOT granted last (last_owner register, reset = I-side, so D wins the first tie).
REQ-026 On grant: latch owner, we (dc_we for D, 0 for I), base = addr with low log2(LINE_WORDS)+2 bits cleared; beat counter = 0; last_owner updated.
REQ-027 XFER: mem_req=1, mem_we=latched we, mem_addr = base + 4*beat, dc_beat = beat.
REQ-028 XFER: mem_wdata = dc_wdata combinationally when the owner is D and we=1, else 0.
REQ-029 XFER, mem_ack=1: beat completes; for a read, rdata=mem_rdata and the owner's rvalid=1 in the same cycle.
REQ-030 XFER, mem_ack=1 with beat < LINE_WORDS-1: beat increments.
REQ-031 XFER, mem_ack=1 with beat = LINE_WORDS-1: go to DONE.
REQ-032 XFER, mem_ack=0: hold all outputs and the beat counter (unbounded wait).
REQ-033 DONE: owner's done=1 for exactly one cycle, mem_req=0, then IDLE.
REQ-034 Requests are sampled only in IDLE; a req still high during DONE is not re-granted until IDLE (minimum one idle cycle between bursts).
REQ-035 A request withdrawn mid-burst shall be ignored; the burst completes.
REQ-036 mem_ack outside XFER shall be ignored; no rvalid or state change.
REQ-037 Addresses shall wrap modulo 2^ADDR_W; base alignment guarantees no intra-burst line crossing.
REQ-038 Both rvalid outputs, and both done outputs, shall never be high in the same cycle.

Reset
REQ-039 On rst: state = IDLE, beat = 0, last_owner = I-side, and every output = 0, asynchronously.
REQ-040 rst mid-burst aborts the transfer; no done pulse is produced, and after release the arbiter shall re-arbitrate from IDLE.

Verification
REQ-041 ic_req=1, ic_addr=0x0000_1234, mem_ack always 1 -> mem_addr 0x1230,0x1234,0x1238,0x123C on 4 consecutive cycles with ic_rvalid; ic_done one cycle later.
REQ-042 ic_req and dc_req (dc_we=0) rise together from reset -> D burst first, then I burst after one IDLE cycle; with both held, grants alternate D,I,D.
REQ-043 dc_req, dc_we=1, dc_addr=0x40, dc_wdata=0xA0+dc_beat -> mem_we=1, writes 0xA0..0xA3 to 0x40..0x4C; dc_rvalid never asserted.
REQ-044 mem_ack pattern 1,0,0,1,1,0,1 -> exactly 4 beats, mem_addr stable during stalls, done after the 4th ack.
REQ-045 rst pulsed after beat 2 of an I refill -> outputs 0 immediately, no ic_done; a pending dc_req is granted in the first IDLE cycle after release.
REQ-046 ic_addr=0xFFFF_FFF8 -> base 0xFFFF_FFF0, beats 0xFFFF_FFF0..0xFFFF_FFFC, no wrap past the line.
